// File: rtl/rtc_time_counter.sv
// rtl/rtc_time_counter.sv - BCD 24-hour time-of-day counter driven by a synchronised 1 Hz tick
module rtc_time_counter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clkin,
    input  logic       rstn,
    input  logic       clk_1hz,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_pulse,
    output logic       min_pulse,
    output logic       hour_pulse,
    output logic       day_pulse,
    output logic       load_err
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   history;
    logic                   tick;
    logic                   load_valid;
    logic                   step;

    // Minutes/seconds: units 9 -> 0 carries into tens, tens 5 -> 0 wraps the field.
    function automatic logic [7:0] inc_sexa(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_hours(input logic [7:0] v);
        if (v == 8'h23)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic sexa_ok(input logic [7:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd5);
    endfunction

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            sync    <= '0;
            history <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], clk_1hz};
            history <= sync[SYNC_STAGES-1];
        end
    end

    assign tick       = sync[SYNC_STAGES-1] & ~history;
    assign load_valid = sexa_ok(load_ss) && sexa_ok(load_mm) &&
                        (load_hh[3:0] <= 4'd9) && (load_hh <= 8'h23);
    // A load cycle always swallows any coincident tick, valid or not.
    assign step       = tick & run & ~load;

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            hh         <= 8'h00;
            mm         <= 8'h00;
            ss         <= 8'h00;
            sec_pulse  <= 1'b0;
            min_pulse  <= 1'b0;
            hour_pulse <= 1'b0;
            day_pulse  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            sec_pulse  <= 1'b0;
            min_pulse  <= 1'b0;
            hour_pulse <= 1'b0;
            day_pulse  <= 1'b0;
            load_err   <= 1'b0;
            if (load) begin
                if (load_valid) begin
                    hh <= load_hh;
                    mm <= load_mm;
                    ss <= load_ss;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (step) begin
                ss        <= inc_sexa(ss);
                sec_pulse <= 1'b1;
                if (ss == 8'h59) begin
                    mm        <= inc_sexa(mm);
                    min_pulse <= 1'b1;
                    if (mm == 8'h59) begin
                        hh         <= inc_hours(hh);
                        hour_pulse <= 1'b1;
                        if (hh == 8'h23)
                            day_pulse <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rtc_time_counter.sv
// tb/tb_rtc_time_counter.sv - self-checking bench for rtc_time_counter
module tb_rtc_time_counter;

    localparam int S = 2;

    logic       clkin = 1'b0;
    logic       rstn = 1'b0;
    logic       clk_1hz = 1'b0;
    logic       run = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_hh = 8'h00;
    logic [7:0] load_mm = 8'h00;
    logic [7:0] load_ss = 8'h00;
    logic [7:0] hh, mm, ss;
    logic       sec_pulse, min_pulse, hour_pulse, day_pulse, load_err;

    int checks = 0;
    int failures = 0;
    int n_sec = 0, n_min = 0, n_hour = 0, n_day = 0, n_err = 0;

    rtc_time_counter #(.SYNC_STAGES(S)) dut (
        .clkin(clkin), .rstn(rstn), .clk_1hz(clk_1hz), .run(run), .load(load),
        .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
        .hh(hh), .mm(mm), .ss(ss),
        .sec_pulse(sec_pulse), .min_pulse(min_pulse), .hour_pulse(hour_pulse),
        .day_pulse(day_pulse), .load_err(load_err)
    );

    always #5 clkin = ~clkin;

    // Model: time as seconds since midnight; tick from the history of clk_1hz samples.
    int        m_t;
    bit        e_sec, e_min, e_hour, e_day, e_err;
    bit [15:0] samp;

    function automatic int bcd_val(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic bit load_ok(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        return h[3:0] <= 9 && m[3:0] <= 9 && s[3:0] <= 9 &&
               bcd_val(h) < 24 && bcd_val(m) < 60 && bcd_val(s) < 60;
    endfunction

    always @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            m_t = 0;
            samp = '0;
            {e_sec, e_min, e_hour, e_day, e_err} = '0;
        end else begin
            {e_sec, e_min, e_hour, e_day, e_err} = '0;
            if (load) begin
                if (load_ok(load_hh, load_mm, load_ss))
                    m_t = bcd_val(load_hh) * 3600 + bcd_val(load_mm) * 60 + bcd_val(load_ss);
                else
                    e_err = 1'b1;
            end else if (samp[S-1] && !samp[S] && run) begin
                m_t = (m_t + 1) % 86400;
                e_sec  = 1'b1;
                e_min  = (m_t % 60) == 0;
                e_hour = (m_t % 3600) == 0;
                e_day  = m_t == 0;
            end
            samp = {samp[14:0], clk_1hz};
        end
    end

    always @(negedge clkin) begin
        logic [28:0] got, exp;
        got = {hh, mm, ss, sec_pulse, min_pulse, hour_pulse, day_pulse, load_err};
        exp = {to_bcd(m_t / 3600), to_bcd((m_t / 60) % 60), to_bcd(m_t % 60),
               e_sec, e_min, e_hour, e_day, e_err};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL cycle_compare t=%0t actual=%h required=%h", $time, got, exp);
        end
        n_sec  += int'(sec_pulse);
        n_min  += int'(min_pulse);
        n_hour += int'(hour_pulse);
        n_day  += int'(day_pulse);
        n_err  += int'(load_err);
    end

    task automatic check_time(input string name, input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s);
        checks++;
        if ({hh, mm, ss} !== {h, m, s}) begin
            failures++;
            $display("FAIL %s actual=%h:%h:%h required=%h:%h:%h", name, hh, mm, ss, h, m, s);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clkin) clk_1hz = 1'b1;
            repeat (4) @(negedge clkin);
            clk_1hz = 1'b0;
            repeat (4) @(negedge clkin);
        end
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        @(negedge clkin);
        load = 1'b1; load_hh = h; load_mm = m; load_ss = s;
        @(negedge clkin);
        load = 1'b0;
        @(negedge clkin);
    endtask

    initial begin
        int s0, m0, h0, d0, e0;
        repeat (3) @(negedge clkin);
        check_time("reset_state", 8'h00, 8'h00, 8'h00);
        rstn = 1'b1;
        run  = 1'b1;

        // Asynchronous reset mid-count, then restart from zero
        do_load(8'h12, 8'h34, 8'h55);
        tick_n(1);
        check_time("pre_reset", 8'h12, 8'h34, 8'h56);
        #2 rstn = 1'b0;
        #1 check_time("async_reset", 8'h00, 8'h00, 8'h00);
        check_int("async_reset_pulses",
                  int'({sec_pulse, min_pulse, hour_pulse, day_pulse, load_err}), 0);
        @(negedge clkin) rstn = 1'b1;
        s0 = n_sec;
        tick_n(3);
        check_time("after_reset_3_ticks", 8'h00, 8'h00, 8'h03);
        check_int("after_reset_sec_pulses", n_sec - s0, 3);

        // Carry chain through a day rollover
        do_load(8'h23, 8'h59, 8'h58);
        s0 = n_sec; m0 = n_min; h0 = n_hour; d0 = n_day;
        tick_n(1);
        check_time("tick_to_235959", 8'h23, 8'h59, 8'h59);
        check_int("no_min_pulse_yet", n_min - m0, 0);
        tick_n(1);
        check_time("day_rollover", 8'h00, 8'h00, 8'h00);
        check_int("day_sec_pulses", n_sec - s0, 2);
        check_int("day_min_pulse", n_min - m0, 1);
        check_int("day_hour_pulse", n_hour - h0, 1);
        check_int("day_day_pulse", n_day - d0, 1);
        do_load(8'h09, 8'h59, 8'h59);
        h0 = n_hour; d0 = n_day;
        tick_n(1);
        check_time("hour_carry_units9", 8'h10, 8'h00, 8'h00);
        check_int("hour_carry_hour_pulse", n_hour - h0, 1);
        check_int("hour_carry_no_day", n_day - d0, 0);

        // Rejected loads leave the time alone
        do_load(8'h01, 8'h02, 8'h03);
        e0 = n_err;
        do_load(8'h24, 8'h00, 8'h00);
        do_load(8'h12, 8'h60, 8'h00);
        do_load(8'h12, 8'h3A, 8'h00);
        check_time("invalid_loads_hold", 8'h01, 8'h02, 8'h03);
        check_int("invalid_load_err_count", n_err - e0, 3);
        do_load(8'h12, 8'h00, 8'h00);
        check_time("valid_after_invalid", 8'h12, 8'h00, 8'h00);
        check_int("valid_no_err", n_err - e0, 3);

        // Load lands in the same cycle as a tick: load wins, tick lost
        do_load(8'h05, 8'h05, 8'h05);
        s0 = n_sec;
        @(negedge clkin) clk_1hz = 1'b1;
        @(negedge clkin);
        @(negedge clkin);
        load = 1'b1; load_hh = 8'h07; load_mm = 8'h00; load_ss = 8'h00;
        @(negedge clkin) load = 1'b0;
        repeat (3) @(negedge clkin);
        clk_1hz = 1'b0;
        repeat (4) @(negedge clkin);
        check_time("collision_load_wins", 8'h07, 8'h00, 8'h00);
        check_int("collision_no_sec_pulse", n_sec - s0, 0);
        tick_n(1);
        check_time("collision_next_tick", 8'h07, 8'h00, 8'h01);

        // Freeze with run low
        do_load(8'h00, 8'h00, 8'h10);
        run = 1'b0;
        s0 = n_sec;
        tick_n(5);
        check_time("freeze_hold", 8'h00, 8'h00, 8'h10);
        check_int("freeze_no_pulses", n_sec - s0, 0);
        do_load(8'h00, 8'h00, 8'h20);
        check_time("load_while_frozen", 8'h00, 8'h00, 8'h20);
        run = 1'b1;
        tick_n(1);
        check_time("resume_one_step", 8'h00, 8'h00, 8'h21);

        // Long high level yields one tick; falling edge yields none
        s0 = n_sec;
        @(negedge clkin) clk_1hz = 1'b1;
        repeat (1000) @(negedge clkin);
        clk_1hz = 1'b0;
        repeat (10) @(negedge clkin);
        check_int("long_high_one_tick", n_sec - s0, 1);
        check_time("long_high_time", 8'h00, 8'h00, 8'h22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
